// File: rtl/csr_access_unit_if.sv
// CSR access unit bus: issue request, regfile read/write port,
// and response handshake.
interface csr_access_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_src;
  logic                  req_src_zero;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_illegal;

  modport master (
    output req_valid, req_op, req_addr, req_src,
    output req_src_zero, flush, read_data, resp_ready,
    input  req_ready, read_addr, write_en, write_addr,
    input  write_data, resp_valid, resp_data, resp_illegal
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_src,
    input  req_src_zero, flush, read_data, resp_ready,
    output req_ready, read_addr, write_en, write_addr,
    output write_data, resp_valid, resp_data, resp_illegal
  );
endinterface

// File: rtl/csr_access_unit.sv
// CSR read-modify-write sequencer: IDLE -> READ -> WRITE -> RESP,
// one request in flight, RW/RS/RC ops with read-only CSR detection.
module csr_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input logic               clk,
  input logic               rst,
  csr_access_unit_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [1:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] src_q;
  logic                  zero_q;
  logic [DATA_WIDTH-1:0] old_q;

  logic                  ro;
  logic                  would_wr;
  logic                  do_wr;
  logic                  is_ill;
  logic [DATA_WIDTH-1:0] new_val;

  always_comb begin
    ro       = (addr_q[ADDR_WIDTH-1 -: 2] == 2'b11);
    // RS/RC with a zero operand is a pure read and never writes
    would_wr = (op_q == 2'b01) ||
               ((op_q != 2'b00) && !zero_q);
    do_wr    = would_wr && !ro;
    is_ill   = (op_q == 2'b00) || (ro && would_wr);
    unique case (op_q)
      2'b10:   new_val = old_q | src_q;
      2'b11:   new_val = old_q & ~src_q;
      default: new_val = src_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      src_q   <= '0;
      zero_q  <= 1'b0;
      old_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.req_valid) begin
        op_q   <= bus.req_op;
        addr_q <= bus.req_addr;
        src_q  <= bus.req_src;
        zero_q <= bus.req_src_zero;
      end
      if (state_q == READ) begin
        old_q <= bus.read_data;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    bus.req_ready    = 1'b0;
    bus.read_addr    = '0;
    bus.write_en     = 1'b0;
    bus.write_addr   = '0;
    bus.write_data   = '0;
    bus.resp_valid   = 1'b0;
    bus.resp_data    = '0;
    bus.resp_illegal = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = !rst;
        if (bus.req_valid && !rst) begin
          state_d = READ;
        end
      end
      READ: begin
        bus.read_addr = addr_q;
        state_d = bus.flush ? IDLE : WRITE;
      end
      WRITE: begin
        // flush is ignored here so the write stays atomic
        bus.write_en   = do_wr;
        bus.write_addr = addr_q;
        bus.write_data = new_val;
        state_d = RESP;
      end
      RESP: begin
        bus.resp_valid   = !bus.flush;
        bus.resp_illegal = is_ill && !bus.flush;
        if (!bus.flush && op_q != 2'b00) begin
          bus.resp_data = old_q;
        end
        if (bus.flush || bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_csr_access_unit.sv
// Randomized bench for csr_access_unit against a transaction-level
// CSR model, plus fixed scenarios pinned with literal values.
module tb_csr_access_unit;
  localparam int DW = 32;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_access_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  csr_access_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] mem [64];
  logic [DW-1:0] ref_mem [64];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_a = '0;
  logic [DW-1:0] pl_v = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_v;
    else if (bus.write_en) mem[bus.write_addr] <= bus.write_data;
  end
  assign bus.read_data = mem[bus.read_addr];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_acc = 0;
  bit active = 1'b0;
  logic [AW-1:0] m_addr;
  logic          m_we, m_ill;
  logic [DW-1:0] m_new, m_resp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chkw(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chka(string nm, logic [AW-1:0] act, logic [AW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chkb(string nm, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // Per-cycle comparison: expected outputs follow from the cycle offset
  // since acceptance (read at +1, write at +2, response from +3).
  always @(negedge clk) begin : cmp
    int rel;
    if (!rst) begin
      rel = cyc - t_acc;
      if (!active || rel == 0) begin
        chkb("req_ready", bus.req_ready, 1'b1);
        chkb("we_idle", bus.write_en, 1'b0);
        chkb("rv_idle", bus.resp_valid, 1'b0);
        chka("raddr_idle", bus.read_addr, '0);
      end else if (rel == 1) begin
        chkb("rdy_read", bus.req_ready, 1'b0);
        chka("raddr_read", bus.read_addr, m_addr);
        chkb("we_read", bus.write_en, 1'b0);
        chkb("rv_read", bus.resp_valid, 1'b0);
      end else if (rel == 2) begin
        chkb("rdy_write", bus.req_ready, 1'b0);
        chka("raddr_write", bus.read_addr, '0);
        chkb("we_write", bus.write_en, m_we);
        chkb("rv_write", bus.resp_valid, 1'b0);
        if (m_we) begin
          chka("waddr", bus.write_addr, m_addr);
          chkw("wdata", bus.write_data, m_new);
        end
      end else begin
        chkb("rdy_resp", bus.req_ready, 1'b0);
        chka("raddr_resp", bus.read_addr, '0);
        chkb("we_resp", bus.write_en, 1'b0);
        chkb("rv_resp", bus.resp_valid, !bus.flush);
        if (!bus.flush) begin
          chkw("resp_data", bus.resp_data, m_resp);
          chkb("resp_ill", bus.resp_illegal, m_ill);
        end
      end
    end
  end

  task automatic preload(logic [AW-1:0] a, logic [DW-1:0] v);
    pl_en = 1'b1;
    pl_a = a;
    pl_v = v;
    ref_mem[a] = v;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic issue(logic [1:0] op, logic [AW-1:0] a,
                       logic [DW-1:0] s, logic z);
    logic would, ro;
    logic [DW-1:0] old;
    bus.req_op = op;
    bus.req_addr = a;
    bus.req_src = s;
    bus.req_src_zero = z;
    bus.req_valid = 1'b1;
    old = ref_mem[a];
    ro = (a[AW-1:AW-2] == 2'b11);
    case (op)
      2'b01:   m_new = s;
      2'b10:   m_new = old | s;
      2'b11:   m_new = old & ~s;
      default: m_new = '0;
    endcase
    would = (op != 2'b00) && (op == 2'b01 || !z);
    m_ill = (op == 2'b00) || (ro && would);
    m_we = would && !ro;
    m_resp = (op == 2'b00) ? '0 : old;
    m_addr = a;
    t_acc = cyc;
    active = 1'b1;
  endtask

  // fm: 0 none, 1 flush in READ, 2 flush in WRITE, 3 flush in RESP
  task automatic xact(input logic [1:0] op, input logic [AW-1:0] a,
                      input logic [DW-1:0] s, input logic z,
                      input int stall, input int fm,
                      output logic [DW-1:0] rd, output logic il);
    rd = 'x;
    il = 1'bx;
    issue(op, a, s, z);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (fm == 1) begin
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      active = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (fm == 2) bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    if (m_we) ref_mem[a] = m_new;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    if (fm == 3) begin
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      active = 1'b0;
      return;
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    rd = bus.resp_data;
    il = bus.resp_illegal;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    active = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic il;
    logic [1:0] op;
    logic [AW-1:0] a, last_a;
    logic [DW-1:0] s;
    logic z;
    int r, fm;
    bus.req_valid = 1'b0;
    bus.req_op = '0;
    bus.req_addr = '0;
    bus.req_src = '0;
    bus.req_src_zero = 1'b0;
    bus.flush = 1'b0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 64; i++) preload(AW'(i), $urandom);
    chkb("rst_ready", bus.req_ready, 1'b0);
    chkb("rst_we", bus.write_en, 1'b0);
    chkb("rst_rv", bus.resp_valid, 1'b0);
    chkw("rst_rdata", bus.resp_data, '0);
    rst = 1'b0;

    preload(6'd5, 32'hA5);
    xact(2'b01, 6'd5, 32'h1234, 1'b0, 0, 0, rd, il);
    chkw("rw_old", rd, 32'hA5);
    chkb("rw_ill", il, 1'b0);
    chkw("rw_mem", mem[5], 32'h1234);

    preload(6'd3, 32'hF0);
    xact(2'b10, 6'd3, 32'h0F, 1'b0, 0, 0, rd, il);
    chkw("rs_old", rd, 32'hF0);
    chkw("rs_mem", mem[3], 32'hFF);
    xact(2'b11, 6'd3, 32'h30, 1'b0, 0, 0, rd, il);
    chkw("rc_old", rd, 32'hFF);
    chkw("rc_mem", mem[3], 32'hCF);

    preload(6'h30, 32'h55);
    xact(2'b10, 6'h30, 32'h0, 1'b1, 0, 0, rd, il);
    chkw("rsz_old", rd, 32'h55);
    chkb("rsz_ill", il, 1'b0);
    xact(2'b01, 6'h30, 32'h9, 1'b0, 0, 0, rd, il);
    chkw("ro_old", rd, 32'h55);
    chkb("ro_ill", il, 1'b1);
    chkw("ro_mem", mem[6'h30], 32'h55);

    xact(2'b00, 6'd5, 32'h77, 1'b0, 0, 0, rd, il);
    chkw("op0_data", rd, 32'h0);
    chkb("op0_ill", il, 1'b1);

    preload(6'd7, 32'h11);
    xact(2'b01, 6'd7, 32'h1, 1'b0, 4, 0, rd, il);
    chkw("bp_old", rd, 32'h11);

    xact(2'b01, 6'd5, 32'hDEAD, 1'b0, 0, 1, rd, il);
    chkw("flr_mem", mem[5], 32'h1234);
    xact(2'b01, 6'd5, 32'hBEEF, 1'b0, 0, 2, rd, il);
    chkw("flw_old", rd, 32'h1234);
    chkw("flw_mem", mem[5], 32'hBEEF);
    xact(2'b10, 6'd5, 32'h10000, 1'b0, 1, 3, rd, il);
    chkw("flp_mem", mem[5], 32'h1BEEF);

    preload(6'd9, 32'h99);
    issue(2'b01, 6'd9, 32'h7777_0000, 1'b0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chkb("pre_rst_we", bus.write_en, 1'b1);
    #2;
    rst = 1'b1;
    active = 1'b0;
    #1;
    chkb("arst_we", bus.write_en, 1'b0);
    chkb("arst_ready", bus.req_ready, 1'b0);
    chkb("arst_rv", bus.resp_valid, 1'b0);
    chkb("arst_ill", bus.resp_illegal, 1'b0);
    chkw("arst_rdata", bus.resp_data, '0);
    chka("arst_waddr", bus.write_addr, '0);
    chkw("arst_wdata", bus.write_data, '0);
    chka("arst_raddr", bus.read_addr, '0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chkw("arst_mem", mem[9], 32'h99);

    last_a = 6'd1;
    for (int n = 0; n < 200; n++) begin
      op = 2'($urandom_range(0, 3));
      r = int'($urandom_range(0, 9));
      if (r < 3) a = last_a;
      else if (r < 5) a = AW'(8'h30 + 8'($urandom_range(0, 15)));
      else a = AW'($urandom_range(0, 63));
      last_a = a;
      z = ($urandom_range(0, 3) == 0);
      s = z ? '0 : $urandom;
      r = int'($urandom_range(0, 9));
      fm = (r < 3) ? r + 1 : 0;
      xact(op, a, s, z, int'($urandom_range(0, 3)), fm, rd, il);
      if ($urandom_range(0, 3) == 0) begin
        bus.flush = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
        bus.flush = 1'b0;
      end
    end

    for (int i = 0; i < 64; i++) chkw("final_mem", mem[i], ref_mem[i]);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
